// File: rtl/imem_load_ctrl.sv
// Instruction SRAM port owner: boot-loads a valid/ready word stream into SRAM while
// holding the core in reset, then serves IF-stage fetch reads until a new load starts.
module imem_load_ctrl #(
    parameter int IDX_W    = 8,
    parameter int DATA_W   = 32,
    parameter int BASE_IDX = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              if_req,
    input  logic [IDX_W-1:0]  if_idx,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [IDX_W-1:0]  sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              cpu_rst,
    output logic [IDX_W:0]    ld_count,
    output logic              ld_done,
    output logic              ld_err
);

    localparam int              DEPTH    = 2 ** IDX_W;
    localparam logic [IDX_W:0]  CAP      = (IDX_W + 1)'(DEPTH - BASE_IDX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] BASE_PTR = IDX_W'(BASE_IDX);
    localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]  CNT_ONE  = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     ld_count_q, ld_count_d;
    logic               ld_err_q, ld_err_d;
    logic               if_rvalid_q, if_rvalid_d;

    // Next-state, write/fetch port steering and session bookkeeping
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ld_count_d  = ld_count_q;
        ld_err_d    = ld_err_q;
        ld_ready    = 1'b0;
        if_gnt      = 1'b0;
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    ptr_d      = BASE_PTR;
                    ld_count_d = '0;
                    ld_err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    sram_en    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = ptr_q;
                    sram_wdata = ld_data;
                    if (ld_count_q == CAP) begin
                        ld_count_d = ld_count_q;
                    end else begin
                        ld_count_d = ld_count_q + CNT_ONE;
                    end
                    // The top index is terminal: the pointer never wraps back into loaded code
                    if (ld_last) begin
                        state_d = S_DRAIN;
                    end else if (ptr_q == LAST_IDX) begin
                        ld_err_d = 1'b1;
                        state_d  = S_DRAIN;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    ptr_d      = BASE_PTR;
                    ld_count_d = '0;
                    ld_err_d   = 1'b0;
                end else if (if_req) begin
                    if_gnt    = 1'b1;
                    sram_en   = 1'b1;
                    sram_addr = if_idx;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if_rvalid_d = if_gnt;
    end

    // State and session registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            ld_count_q  <= '0;
            ld_err_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ld_count_q  <= ld_count_d;
            ld_err_q    <= ld_err_d;
            if_rvalid_q <= if_rvalid_d;
        end
    end

    // SRAM read data arrives the cycle after the grant, so it is passed through under rvalid
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rvalid_q ? sram_rdata : '0;
    assign cpu_rst   = (state_q != S_RUN);
    assign ld_done   = (state_q == S_RUN);
    assign ld_count  = ld_count_q;
    assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: main instance (IDX_W=8) plus a small IDX_W=3
// instance for the overflow case, each with its own behavioural SRAM.
module tb_imem_load_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Main instance
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, if_req = 1'b0;
    logic [31:0] ld_data = 32'h0;
    logic [7:0]  if_idx = 8'h0;
    logic        ld_ready, if_gnt, if_rvalid, sram_en, sram_we, cpu_rst, ld_done, ld_err;
    logic [31:0] if_rdata, sram_wdata, sram_rdata;
    logic [7:0]  sram_addr;
    logic [8:0]  ld_count;
    logic [31:0] mem [256];

    imem_load_ctrl #(.IDX_W(8), .DATA_W(32), .BASE_IDX(0)) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last), .if_req(if_req),
        .if_idx(if_idx), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .cpu_rst(cpu_rst),
        .ld_count(ld_count), .ld_done(ld_done), .ld_err(ld_err)
    );

    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    end

    // Small instance for capacity overflow
    logic        b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0, b_req = 1'b0;
    logic [31:0] b_data = 32'h0;
    logic [2:0]  b_idx = 3'h0;
    logic        b_ready, b_gnt, b_rvalid, b_en, b_we, b_cpu_rst, b_done, b_err;
    logic [31:0] b_rdata, b_wdata, b_srdata;
    logic [2:0]  b_addr;
    logic [3:0]  b_count;
    logic [31:0] mem_b [8];

    imem_load_ctrl #(.IDX_W(3), .DATA_W(32), .BASE_IDX(0)) dut_b (
        .clk(clk), .reset(reset), .ld_start(b_start), .ld_valid(b_valid),
        .ld_ready(b_ready), .ld_data(b_data), .ld_last(b_last), .if_req(b_req),
        .if_idx(b_idx), .if_gnt(b_gnt), .if_rvalid(b_rvalid), .if_rdata(b_rdata),
        .sram_en(b_en), .sram_we(b_we), .sram_addr(b_addr),
        .sram_wdata(b_wdata), .sram_rdata(b_srdata), .cpu_rst(b_cpu_rst),
        .ld_count(b_count), .ld_done(b_done), .ld_err(b_err)
    );

    always @(posedge clk) begin
        if (b_en && b_we) mem_b[b_addr] <= b_wdata;
        if (b_en && !b_we) b_srdata <= mem_b[b_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t1 [5];
    logic [31:0] t2 [3];

    initial begin
        t1[0] = 32'h01400113; t1[1] = 32'h00100A13; t1[2] = 32'h00100A13;
        t1[3] = 32'h00100A13; t1[4] = 32'h00510193;
        t2[0] = 32'hA0A0A0A0; t2[1] = 32'hA1A1A1A1; t2[2] = 32'hA2A2A2A2;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem_b[i] = 32'h0;

        // Reset values
        #2;
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_ld_count", ld_count, 9'd0);
        chk("rst_ld_err", ld_err, 1'b0);
        chk("rst_ld_done", ld_done, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_sram_addr", sram_addr, 8'h0);
        step();
        reset = 1'b0;
        step();
        chk("idle_ready", ld_ready, 1'b0);

        // T1: five-word load, then fetch index 4
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("t1_load_ready", ld_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = t1[i]; ld_last = (i == 4);
            #1;
            chk("t1_we", {sram_en, sram_we}, 2'b11);
            chk("t1_addr", sram_addr, 8'(i));
            chk("t1_wdata", sram_wdata, t1[i]);
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("t1_drain_ready", ld_ready, 1'b0);
        chk("t1_drain_cpu_rst", cpu_rst, 1'b1);
        chk("t1_count", ld_count, 9'd5);
        step();
        chk("t1_run_cpu_rst", cpu_rst, 1'b0);
        chk("t1_run_done", ld_done, 1'b1);
        for (int i = 0; i < 5; i++) chk("t1_mem", mem[i], t1[i]);
        if_req = 1'b1; if_idx = 8'd4;
        #1;
        chk("t1_gnt", if_gnt, 1'b1);
        chk("t1_rd_addr", {sram_en, sram_we, sram_addr}, {2'b10, 8'd4});
        step();
        if_req = 1'b0;
        #1;
        chk("t1_rvalid", if_rvalid, 1'b1);
        chk("t1_rdata", if_rdata, 32'h00510193);
        step();
        chk("t1_rvalid_drop", if_rvalid, 1'b0);

        // T4: fetch every cycle, ld_start mid-stream
        if_req = 1'b1; if_idx = 8'd1;
        step();
        chk("t4_rvalid_pre", if_rvalid, 1'b1);
        ld_start = 1'b1; if_idx = 8'd2;
        #1;
        chk("t4_gnt_forced0", if_gnt, 1'b0);
        chk("t4_trailing_rvalid", if_rvalid, 1'b1);
        chk("t4_trailing_rdata", if_rdata, 32'h00100A13);
        step();
        ld_start = 1'b0;
        #1;
        chk("t4_cpu_rst", cpu_rst, 1'b1);
        chk("t4_done", ld_done, 1'b0);
        chk("t4_count", ld_count, 9'd0);
        chk("t4_gnt_in_load", if_gnt, 1'b0);
        chk("t4_rvalid_after", if_rvalid, 1'b0);
        if_req = 1'b0;

        // T2: valid toggles; only valid cycles write, contiguous from 0
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = t2[i]; ld_last = (i == 2);
            #1;
            chk("t2_addr", {sram_we, sram_addr}, {1'b1, 8'(i)});
            step();
            if (i < 2) begin
                ld_valid = 1'b0; ld_data = 32'hFFFFFFFF; ld_last = 1'b0;
                #1;
                chk("t2_gap_en", sram_en, 1'b0);
                step();
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("t2_count", ld_count, 9'd3);
        step();
        chk("t2_run", cpu_rst, 1'b0);
        for (int i = 0; i < 3; i++) chk("t2_mem", mem[i], t2[i]);
        chk("t2_mem3_kept", mem[3], 32'h00100A13);

        // T6: single word with ld_last on first LOAD cycle
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'hDEADBEEF;
        #1;
        chk("t6_write", {sram_we, sram_addr}, {1'b1, 8'd0});
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("t6_count", ld_count, 9'd1);
        step();
        chk("t6_run", {cpu_rst, ld_done, ld_err}, 3'b010);
        chk("t6_mem", mem[0], 32'hDEADBEEF);

        // T5: async reset after 2 of 5 words
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 32'h55000000 + 32'(i);
            step();
        end
        chk("t5_count_pre", ld_count, 9'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_cpu_rst", cpu_rst, 1'b1);
        chk("t5_count", ld_count, 9'd0);
        chk("t5_ready", ld_ready, 1'b0);
        chk("t5_en", sram_en, 1'b0);
        reset = 1'b0;
        if_req = 1'b1; if_idx = 8'd0;
        step();
        chk("t5_idle_ignore", {ld_ready, sram_en, if_gnt}, 3'b000);
        step();
        chk("t5_still_idle", {cpu_rst, ld_count}, {1'b1, 9'd0});
        chk("t5_rvalid", if_rvalid, 1'b0);
        ld_valid = 1'b0; if_req = 1'b0;
        chk("t5_mem1", mem[1], 32'h55000001);
        chk("t5_mem2_kept", mem[2], t2[2]);

        // T3: IDX_W=3, ten words without ld_last
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b_valid = 1'b1; b_data = 32'h100 + 32'(i);
            #1;
            chk("t3_ready", b_ready, (i < 8));
            chk("t3_we", b_we, (i < 8));
            step();
        end
        b_valid = 1'b0;
        chk("t3_err", b_err, 1'b1);
        chk("t3_count", b_count, 4'd8);
        chk("t3_run", b_cpu_rst, 1'b0);
        chk("t3_mem7", mem_b[7], 32'h107);
        chk("t3_mem0", mem_b[0], 32'h100);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("t3_err_clear", {b_err, b_count}, {1'b0, 4'd0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
